// File: rtl/ocs_slot_scheduler.sv
// Round-robin slot scheduler for a 4x4 optical circuit switch.
// Optional grant timeout: define OCS_SCHED_TIMEOUT_EN.
module ocs_slot_scheduler #(
   parameter int unsigned P_GUARD   = 4,
   parameter int unsigned P_SLOT    = 16,
   parameter int unsigned P_TIMEOUT = 64
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [3:0] i_port_req,
   input  logic [7:0] i_port_dst,
   output logic [7:0] o_4x4_req,
   output logic       o_4x4_valid,
   input  logic       i_grant_valid,
   output logic       o_config_end,
   output logic [3:0] o_port_ack,
   output logic       o_busy,
   output logic       o_err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_MATCH,
      S_ISSUE,
      S_WAIT_GNT,
      S_GUARD,
      S_SLOT,
      S_END
   } state_t;

   localparam logic [15:0] GUARD_LAST = 16'(P_GUARD - 1);
   localparam logic [15:0] SLOT_LAST  = 16'(P_SLOT - 1);

   if (P_GUARD < 1 || P_GUARD > 255 || P_SLOT < 1 || P_SLOT > 65535 ||
       P_TIMEOUT < 1 || P_TIMEOUT > 65535) begin : g_param_check
      $error("ocs_slot_scheduler: parameter out of legal range");
   end

   state_t          state;
   logic [1:0]      ptr;
   logic [3:0]      req_q;
   logic [3:0][1:0] dst_q;
   logic [15:0]     cnt;
   logic [3:0]      ack_q;

   logic [3:0][1:0] match_perm;
   logic [3:0]      match_ack;
   logic [3:0]      taken;
   logic [1:0]      vis;
   logic            found;

`ifdef OCS_SCHED_TIMEOUT_EN
   localparam logic [15:0] TMO_LAST = 16'(P_TIMEOUT - 1);
   logic [15:0] tmo_cnt;
`else
   assign o_err = 1'b0;
`endif

   always_comb begin
      match_perm = '0;
      match_ack  = '0;
      taken      = '0;
      vis        = '0;
      found      = 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
         vis = ptr + 2'(i);
         if (req_q[vis] && !taken[dst_q[vis]]) begin
            taken[dst_q[vis]] = 1'b1;
            match_ack[vis]    = 1'b1;
            match_perm[vis]   = dst_q[vis];
         end
      end
      // Unmatched inputs take the lowest free outputs so the switch always sees a permutation.
      for (int unsigned k = 0; k < 4; k++) begin
         found = 1'b0;
         if (!match_ack[2'(k)]) begin
            for (int unsigned o = 0; o < 4; o++) begin
               if (!found && !taken[2'(o)]) begin
                  found            = 1'b1;
                  taken[2'(o)]     = 1'b1;
                  match_perm[2'(k)] = 2'(o);
               end
            end
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state        <= S_IDLE;
         ptr          <= '0;
         req_q        <= '0;
         dst_q        <= '0;
         cnt          <= '0;
         ack_q        <= '0;
         o_4x4_req    <= '0;
         o_4x4_valid  <= 1'b0;
         o_config_end <= 1'b0;
         o_port_ack   <= '0;
         o_busy       <= 1'b0;
`ifdef OCS_SCHED_TIMEOUT_EN
         o_err        <= 1'b0;
         tmo_cnt      <= '0;
`endif
      end else begin
         o_4x4_valid  <= 1'b0;
         o_config_end <= 1'b0;
`ifdef OCS_SCHED_TIMEOUT_EN
         o_err        <= 1'b0;
`endif
         case (state)
            S_IDLE: begin
               if (|i_port_req) begin
                  state  <= S_MATCH;
                  req_q  <= i_port_req;
                  dst_q  <= i_port_dst;
                  o_busy <= 1'b1;
               end
            end
            S_MATCH: begin
               state       <= S_ISSUE;
               o_4x4_req   <= match_perm;
               ack_q       <= match_ack;
               o_4x4_valid <= 1'b1;
            end
            S_ISSUE: begin
               cnt <= '0;
`ifdef OCS_SCHED_TIMEOUT_EN
               tmo_cnt <= '0;
`endif
               state <= i_grant_valid ? S_GUARD : S_WAIT_GNT;
            end
            S_WAIT_GNT: begin
               if (i_grant_valid) begin
                  state <= S_GUARD;
                  cnt   <= '0;
               end
`ifdef OCS_SCHED_TIMEOUT_EN
               else if (tmo_cnt == TMO_LAST) begin
                  state     <= S_IDLE;
                  o_err     <= 1'b1;
                  o_busy    <= 1'b0;
                  o_4x4_req <= '0;
               end else begin
                  tmo_cnt <= tmo_cnt + 16'd1;
               end
`endif
            end
            S_GUARD: begin
               if (cnt == GUARD_LAST) begin
                  cnt        <= '0;
                  state      <= S_SLOT;
                  o_port_ack <= ack_q;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            S_SLOT: begin
               if (cnt == SLOT_LAST) begin
                  cnt          <= '0;
                  state        <= S_END;
                  o_port_ack   <= '0;
                  o_config_end <= 1'b1;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            S_END: begin
               state     <= S_IDLE;
               ptr       <= ptr + 2'd1;
               o_4x4_req <= '0;
               o_busy    <= 1'b0;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ocs_slot_scheduler.sv
// Scoreboard bench for ocs_slot_scheduler: randomized slots against a rule-level model.
module tb_ocs_slot_scheduler;

   localparam int G = 4;
   localparam int S = 16;
   localparam int T = 64;
   localparam int M_NORMAL = 0;
   localparam int M_RESET  = 1;
   localparam int M_NOGNT  = 2;

   logic       i_clk = 1'b0;
   logic       i_rst_n = 1'b0;
   logic [3:0] i_port_req = '0;
   logic [7:0] i_port_dst = '0;
   logic       i_grant_valid = 1'b0;
   logic [7:0] o_4x4_req;
   logic       o_4x4_valid;
   logic       o_config_end;
   logic [3:0] o_port_ack;
   logic       o_busy;
   logic       o_err;

   always #5 i_clk = ~i_clk;

   ocs_slot_scheduler #(.P_GUARD(G), .P_SLOT(S), .P_TIMEOUT(T)) dut (
      .i_clk(i_clk),
      .i_rst_n(i_rst_n),
      .i_port_req(i_port_req),
      .i_port_dst(i_port_dst),
      .o_4x4_req(o_4x4_req),
      .o_4x4_valid(o_4x4_valid),
      .i_grant_valid(i_grant_valid),
      .o_config_end(o_config_end),
      .o_port_ack(o_port_ack),
      .o_busy(o_busy),
      .o_err(o_err)
   );

   typedef struct {
      logic [7:0] perm;
      logic [3:0] ack;
   } exp_t;

   exp_t       perm_q[$];
   exp_t       ack_q[$];
   exp_t       mon_e;
   int         n_tests = 0;
   int         n_fail = 0;
   logic [1:0] mptr = '0;
   logic [3:0] prev_ack = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic exp_t mk(input logic [7:0] perm, input logic [3:0] ack);
      exp_t e;
      e.perm = perm;
      e.ack  = ack;
      return e;
   endfunction

   // Each output goes to the first requester of it in rotation order from p;
   // leftover inputs take leftover outputs, both in ascending order.
   function automatic exp_t model(input logic [3:0] req, input logic [7:0] dst, input logic [1:0] p);
      exp_t e;
      int   owner[4];
      int   free_q[$];
      int   port;
      e.perm = '0;
      e.ack  = '0;
      for (int d = 0; d < 4; d++) begin
         owner[d] = -1;
         for (int j = 0; j < 4; j++) begin
            port = (int'(p) + j) % 4;
            if (owner[d] < 0 && req[port] && int'(dst[2*port +: 2]) == d) owner[d] = port;
         end
         if (owner[d] >= 0) begin
            e.perm[2*owner[d] +: 2] = 2'(d);
            e.ack[owner[d]] = 1'b1;
         end else begin
            free_q.push_back(d);
         end
      end
      for (int k = 0; k < 4; k++)
         if (!e.ack[k]) e.perm[2*k +: 2] = 2'(free_q.pop_front());
      return e;
   endfunction

   // Monitor: permutation on each valid strobe, ack vector and held permutation on ack rise.
   always @(negedge i_clk) begin
      if (i_rst_n) begin
         if (o_4x4_valid) begin
            if (perm_q.size() == 0) begin
               check("unexpected_valid", 32'd1, 32'd0);
            end else begin
               mon_e = perm_q.pop_front();
               check("perm_on_valid", 32'(o_4x4_req), 32'(mon_e.perm));
               ack_q.push_back(mon_e);
            end
         end
         if (o_port_ack != '0 && prev_ack == '0) begin
            if (ack_q.size() == 0) begin
               check("unexpected_ack", 32'(o_port_ack), 32'd0);
            end else begin
               mon_e = ack_q.pop_front();
               check("ack_value", 32'(o_port_ack), 32'(mon_e.ack));
               check("perm_held_in_slot", 32'(o_4x4_req), 32'(mon_e.perm));
            end
         end
      end
      prev_ack = o_port_ack;
   end

   task automatic issue(input logic [3:0] req, input logic [7:0] dst, input exp_t e);
      i_port_req = req;
      i_port_dst = dst;
      perm_q.push_back(e);
   endtask

   task automatic finish_txn(input int mode, input int lat, input int gdelay, input bit early_gnt);
      int k;
      bit seen;
      int rise, width, cfg_at, cfg_cnt, busy_fall;
      bit ack_seen;
      seen = 0;
      k = 0;
      while (!seen && k < 8) begin
         @(negedge i_clk);
         k++;
         i_grant_valid = (k == 1) ? early_gnt : 1'b0;
         seen = o_4x4_valid;
      end
      check("valid_latency", 32'(k), 32'(lat));
      if (!seen) return;

      if (mode == M_NOGNT) begin
         ack_seen = 0;
         k = 0;
`ifdef OCS_SCHED_TIMEOUT_EN
         seen = 0;
         while (!seen && k < T + 10) begin
            @(negedge i_clk);
            k++;
            seen = o_err;
            if (o_port_ack != '0) ack_seen = 1;
         end
         check("timeout_latency", 32'(k), 32'(T + 1));
         check("timeout_busy", 32'(o_busy), 32'd0);
         check("timeout_no_ack", 32'(ack_seen), 32'd0);
`else
         while (o_busy && !o_err && k < T + 40) begin
            @(negedge i_clk);
            k++;
         end
         check("wait_gnt_forever", 32'(k), 32'(T + 40));
         i_rst_n = 1'b0;
         i_port_req = '0;
         @(negedge i_clk);
         i_rst_n = 1'b1;
         mptr = '0;
`endif
         ack_q.delete();
         return;
      end

      repeat (gdelay) @(negedge i_clk);
      i_grant_valid = 1'b1;
      rise = -1; width = 0; cfg_at = -1; cfg_cnt = 0; busy_fall = -1;
      for (int i = 1; i <= G + S + 2; i++) begin
         @(negedge i_clk);
         if (i == 1) i_grant_valid = 1'b0;
         if (i == G + 3) i_grant_valid = 1'b1;
         if (i == G + 4) i_grant_valid = 1'b0;
         if (mode == M_NORMAL && i == 2) begin
            i_port_req = 4'($urandom);
            i_port_dst = 8'($urandom);
         end
         if (mode == M_RESET && i == G + 6) begin
            i_rst_n = 1'b0;
            #1;
            check("reset_mid_slot_outputs",
                  32'({o_4x4_req, o_4x4_valid, o_config_end, o_port_ack, o_busy, o_err}), 32'd0);
            @(posedge i_clk);
            @(negedge i_clk);
            i_rst_n = 1'b1;
            return;
         end
         if (o_port_ack != '0) begin
            if (rise < 0) rise = i;
            width++;
         end
         if (o_config_end) begin
            if (cfg_at < 0) cfg_at = i;
            cfg_cnt++;
         end
         if (!o_busy && busy_fall < 0) busy_fall = i;
      end
      check("ack_rise", 32'(rise), 32'(G + 1));
      check("ack_width", 32'(width), 32'(S));
      check("config_end_at", 32'(cfg_at), 32'(G + S + 1));
      check("config_end_count", 32'(cfg_cnt), 32'd1);
      check("busy_fall", 32'(busy_fall), 32'(G + S + 2));
      check("perm_zero_idle", 32'(o_4x4_req), 32'd0);
      mptr = mptr + 2'd1;
   endtask

   task automatic rand_txn(input int mode);
      logic [3:0] req;
      logic [7:0] dst;
      req = 4'($urandom_range(1, 15));
      dst = 8'($urandom);
      issue(req, dst, model(req, dst, mptr));
      finish_txn(mode, 2, $urandom_range(0, 4), 1'($urandom));
   endtask

   initial begin
      logic [3:0] hreq;
      logic [7:0] hdst;
      repeat (3) @(negedge i_clk);
      check("reset_state",
            32'({o_4x4_req, o_4x4_valid, o_config_end, o_port_ack, o_busy, o_err}), 32'd0);
      i_rst_n = 1'b1;

      // Two ports contending for output 3, then the same again with ptr = 1
      issue(4'b0101, 8'h33, mk(8'h93, 4'b0001));
      finish_txn(M_NORMAL, 2, 1, 1'b0);
      issue(4'b0101, 8'h33, mk(8'hB4, 4'b0100));
      finish_txn(M_NORMAL, 2, 0, 1'b1);

      i_rst_n = 1'b0;
      @(negedge i_clk);
      i_rst_n = 1'b1;
      mptr = '0;
      issue(4'hF, 8'hB1, mk(8'hB1, 4'hF));
      finish_txn(M_NORMAL, 2, 3, 1'b0);

      for (int n = 0; n < 16; n++) rand_txn(M_NORMAL);

      rand_txn(M_NOGNT);
      for (int n = 0; n < 3; n++) rand_txn(M_NORMAL);

      hreq = 4'($urandom_range(1, 15));
      hdst = 8'($urandom);
      issue(hreq, hdst, model(hreq, hdst, mptr));
      finish_txn(M_RESET, 2, 1, 1'b0);
      ack_q.delete();
      mptr = '0;
      issue(hreq, hdst, model(hreq, hdst, 2'd0));
      finish_txn(M_NORMAL, 2, 2, 1'b0);

      for (int n = 0; n < 4; n++) rand_txn(M_NORMAL);

      check("perm_queue_drained", 32'(perm_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete, failures so far %0d", n_fail);
      $fatal(1);
   end

endmodule
